// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and decodes every datapath enable and mux select from the state register.
// Optional MULTICYCLE_JUMP_EN enables the j instruction (opcode 0x02) via JUMP.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// FETCH     | read instruction at PC into IR, PC <= PC + 4
// DECODE    | read registers, branch target into ALUOut, dispatch on opcode
// MEM_ADR   | effective address A + sign-extended immediate
// MEM_READ  | load: read memory at ALUOut into MDR
// MEM_WB    | load: write MDR into rt
// MEM_WRITE | store: write B to memory at ALUOut
// EXECUTE   | R-type ALU operation on A and B
// ALU_WB    | R-type: write ALUOut into rd
// BRANCH    | beq/bne compare, PC <= ALUOut on taken branch
// IMM_EXEC  | addi/ori ALU operation on A and immediate
// IMM_WB    | addi/ori: write ALUOut into rt
// JUMP      | PC <= jump target

module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode_i,
    input  logic       zero_i,
    output logic       pc_en_o,
    output logic       i_or_d_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic       reg_dst_o,
    output logic       mem_to_reg_o,
    output logic       reg_write_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [2:0] alu_op_o,
    output logic [1:0] pc_src_o,
    output logic       instr_done_o,
    output logic       illegal_o,
    output logic [3:0] state_o
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADR   = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXECUTE   = 4'd6,
        ALU_WB    = 4'd7,
        BRANCH    = 4'd8,
        IMM_EXEC  = 4'd9,
        IMM_WB    = 4'd10,
        JUMP      = 4'd11
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   illegal_nxt;

    logic pc_write;
    logic branch_eq;
    logic branch_ne;
    logic mem_read;
    logic mem_write;
    logic ir_write;
    logic reg_write;
    logic done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= FETCH;
            illegal_o <= 1'b0;
        end else begin
            state     <= state_nxt;
            illegal_o <= illegal_nxt;
        end
    end

    always_comb begin
        state_nxt    = FETCH;
        illegal_nxt  = 1'b0;
        pc_write     = 1'b0;
        branch_eq    = 1'b0;
        branch_ne    = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        ir_write     = 1'b0;
        reg_write    = 1'b0;
        done         = 1'b0;
        i_or_d_o     = 1'b0;
        reg_dst_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = 2'b00;
        alu_op_o     = ALU_ADD;
        pc_src_o     = 2'b00;

        case (state)
            FETCH: begin
                mem_read    = 1'b1;
                ir_write    = 1'b1;
                alu_src_b_o = 2'b01;
                pc_write    = 1'b1;
                state_nxt   = DECODE;
            end
            DECODE: begin
                alu_src_b_o = 2'b11;
                case (opcode_i)
                    OP_RTYPE:      state_nxt = EXECUTE;
                    OP_LW, OP_SW:  state_nxt = MEM_ADR;
                    OP_ADDI, OP_ORI: state_nxt = IMM_EXEC;
                    OP_BEQ, OP_BNE: state_nxt = BRANCH;
`ifdef MULTICYCLE_JUMP_EN
                    OP_J:          state_nxt = JUMP;
`else
                    OP_J: begin
                        state_nxt   = FETCH;
                        illegal_nxt = 1'b1;
                    end
`endif
                    default: begin
                        state_nxt   = FETCH;
                        illegal_nxt = 1'b1;
                    end
                endcase
            end
            MEM_ADR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                if (opcode_i == OP_LW)
                    state_nxt = MEM_READ;
                else if (opcode_i == OP_SW)
                    state_nxt = MEM_WRITE;
                else
                    state_nxt = FETCH;
            end
            MEM_READ: begin
                mem_read  = 1'b1;
                i_or_d_o  = 1'b1;
                state_nxt = MEM_WB;
            end
            MEM_WB: begin
                reg_write    = 1'b1;
                mem_to_reg_o = 1'b1;
                done         = 1'b1;
            end
            MEM_WRITE: begin
                mem_write = 1'b1;
                i_or_d_o  = 1'b1;
                done      = 1'b1;
            end
            EXECUTE: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = ALU_FUNCT;
                state_nxt   = ALU_WB;
            end
            ALU_WB: begin
                reg_write = 1'b1;
                reg_dst_o = 1'b1;
                done      = 1'b1;
            end
            IMM_EXEC: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                alu_op_o    = (opcode_i == OP_ORI) ? ALU_OR : ALU_ADD;
                state_nxt   = IMM_WB;
            end
            IMM_WB: begin
                reg_write = 1'b1;
                done      = 1'b1;
            end
            BRANCH: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = ALU_SUB;
                pc_src_o    = 2'b01;
                branch_eq   = (opcode_i == OP_BEQ);
                branch_ne   = (opcode_i == OP_BNE);
                done        = 1'b1;
            end
`ifdef MULTICYCLE_JUMP_EN
            JUMP: begin
                pc_src_o = 2'b10;
                pc_write = 1'b1;
                done     = 1'b1;
            end
`else
            JUMP: begin
                state_nxt = FETCH;
            end
`endif
            // codes 12-15: all strobes stay at their zero defaults
            default: state_nxt = FETCH;
        endcase
    end

    // Strobes are gated by reset so an aborted instruction can never write.
    assign pc_en_o      = ~reset & (pc_write | (branch_eq & zero_i) | (branch_ne & ~zero_i));
    assign mem_read_o   = ~reset & mem_read;
    assign mem_write_o  = ~reset & mem_write;
    assign ir_write_o   = ~reset & ir_write;
    assign reg_write_o  = ~reset & reg_write;
    assign instr_done_o = ~reset & done;
    assign state_o      = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed plan items plus a random instruction
// stream checked against an instruction-level model of cycle counts and effects.

module tb_multicycle_control;

    logic       clk;
    logic       reset;
    logic [5:0] opcode_i;
    logic       zero_i;
    logic       pc_en_o;
    logic       i_or_d_o;
    logic       mem_read_o;
    logic       mem_write_o;
    logic       ir_write_o;
    logic       reg_dst_o;
    logic       mem_to_reg_o;
    logic       reg_write_o;
    logic       alu_src_a_o;
    logic [1:0] alu_src_b_o;
    logic [2:0] alu_op_o;
    logic [1:0] pc_src_o;
    logic       instr_done_o;
    logic       illegal_o;
    logic [3:0] state_o;

    int checks;
    int failures;
    logic prev_illegal;
    int exp_seq [0:7];
    int exp_len;

    multicycle_control dut (
        .clk          (clk),
        .reset        (reset),
        .opcode_i     (opcode_i),
        .zero_i       (zero_i),
        .pc_en_o      (pc_en_o),
        .i_or_d_o     (i_or_d_o),
        .mem_read_o   (mem_read_o),
        .mem_write_o  (mem_write_o),
        .ir_write_o   (ir_write_o),
        .reg_dst_o    (reg_dst_o),
        .mem_to_reg_o (mem_to_reg_o),
        .reg_write_o  (reg_write_o),
        .alu_src_a_o  (alu_src_a_o),
        .alu_src_b_o  (alu_src_b_o),
        .alu_op_o     (alu_op_o),
        .pc_src_o     (pc_src_o),
        .instr_done_o (instr_done_o),
        .illegal_o    (illegal_o),
        .state_o      (state_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

`ifdef MULTICYCLE_JUMP_EN
    localparam bit JUMP_EN = 1'b1;
`else
    localparam bit JUMP_EN = 1'b0;
`endif

    // Instruction-level view: the visited state list follows from the opcode class.
    task automatic plan(input logic [5:0] op);
        exp_seq[0] = 0;
        exp_seq[1] = 1;
        exp_len    = 2;
        case (op)
            6'h00: begin exp_seq[2] = 6; exp_seq[3] = 7; exp_len = 4; end
            6'h23: begin exp_seq[2] = 2; exp_seq[3] = 3; exp_seq[4] = 4; exp_len = 5; end
            6'h2B: begin exp_seq[2] = 2; exp_seq[3] = 5; exp_len = 4; end
            6'h08, 6'h0D: begin exp_seq[2] = 9; exp_seq[3] = 10; exp_len = 4; end
            6'h04, 6'h05: begin exp_seq[2] = 8; exp_len = 3; end
            6'h02: if (JUMP_EN) begin exp_seq[2] = 11; exp_len = 3; end
            default: exp_len = 2;
        endcase
    endtask

    // Entry: just after a falling edge in a FETCH cycle. Exit: same, next FETCH.
    task automatic run_instr(input logic [5:0] op);
        logic last, legal, is_br, is_j, cond, writes_reg;
        plan(op);
        legal      = (exp_len > 2);
        is_br      = (op == 6'h04) || (op == 6'h05);
        is_j       = (op == 6'h02) && legal;
        writes_reg = (op == 6'h00) || (op == 6'h23) || (op == 6'h08) || (op == 6'h0D);
        for (int k = 0; k < exp_len; k++) begin
            if (k == 0) opcode_i = op;
            zero_i = 1'($urandom_range(0, 1));
            #1;
            last = (k == exp_len - 1);
            cond = (op == 6'h04) ? zero_i : ~zero_i;
            chk4("state", state_o, 4'(exp_seq[k]));
            chk1("reg_write", reg_write_o, last && writes_reg);
            chk1("mem_write", mem_write_o, last && (op == 6'h2B));
            chk1("instr_done", instr_done_o, last && legal);
            chk1("pc_en", pc_en_o, (k == 0) || (last && is_j) || (last && is_br && cond));
            chk1("illegal", illegal_o, (k == 0) ? prev_illegal : 1'b0);
            chk1("mem_read", mem_read_o, (k == 0) || (op == 6'h23 && k == 3));
            chk1("ir_write", ir_write_o, k == 0);
            if (k == 1) chk4("decode_src_b", {2'b00, alu_src_b_o}, 4'd3);
            if (last && writes_reg) chk1("reg_dst", reg_dst_o, op == 6'h00);
            if (last && op == 6'h23) chk1("mem_to_reg", mem_to_reg_o, 1'b1);
            if (op == 6'h2B && last) chk1("sw_i_or_d", i_or_d_o, 1'b1);
            if (k == 2 && (op == 6'h08 || op == 6'h0D))
                chk4("imm_alu_op", {1'b0, alu_op_o}, (op == 6'h0D) ? 4'd3 : 4'd0);
            if (k == 2 && op == 6'h00) chk4("rtype_alu_op", {1'b0, alu_op_o}, 4'd2);
            if (last && is_br) begin
                chk4("br_alu_op", {1'b0, alu_op_o}, 4'd1);
                chk4("br_pc_src", {2'b00, pc_src_o}, 4'd1);
            end
            if (last && is_j) chk4("jump_pc_src", {2'b00, pc_src_o}, 4'd2);
            @(negedge clk);
        end
        prev_illegal = ~legal;
    endtask

    task automatic chk_reset_quiet(input string tag);
        chk4({tag, "_state"}, state_o, 4'd0);
        chk1({tag, "_pc_en"}, pc_en_o, 1'b0);
        chk1({tag, "_ir_write"}, ir_write_o, 1'b0);
        chk1({tag, "_mem_read"}, mem_read_o, 1'b0);
        chk1({tag, "_mem_write"}, mem_write_o, 1'b0);
        chk1({tag, "_reg_write"}, reg_write_o, 1'b0);
        chk1({tag, "_done"}, instr_done_o, 1'b0);
        chk1({tag, "_illegal"}, illegal_o, 1'b0);
        chk4({tag, "_src_b"}, {2'b00, alu_src_b_o}, 4'd1);
    endtask

    logic [5:0] pool [0:9];

    initial begin
        checks       = 0;
        failures     = 0;
        prev_illegal = 1'b0;
        opcode_i     = 6'h00;
        zero_i       = 1'b0;
        reset        = 1'b1;
        pool[0] = 6'h00; pool[1] = 6'h23; pool[2] = 6'h2B; pool[3] = 6'h08;
        pool[4] = 6'h0D; pool[5] = 6'h04; pool[6] = 6'h05; pool[7] = 6'h02;
        pool[8] = 6'h3F; pool[9] = 6'h11;

        #2;
        chk_reset_quiet("rst0");
        @(posedge clk);
        #2;
        chk_reset_quiet("rst1");
        @(negedge clk);
        reset = 1'b0;

        run_instr(6'h00);
        run_instr(6'h23);
        run_instr(6'h2B);
        opcode_i = 6'h04;
        run_instr(6'h04);
        run_instr(6'h04);
        run_instr(6'h05);
        run_instr(6'h05);
        run_instr(6'h0D);
        run_instr(6'h08);
        run_instr(6'h02);
        run_instr(6'h3F);
        run_instr(6'h00);

        // reset while the load sits in MEM_READ
        opcode_i = 6'h23;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk4("lw_abort_seq", state_o, 4'(k == 0 ? 0 : k == 1 ? 1 : k == 2 ? 2 : 3));
            if (k < 3) @(negedge clk);
        end
        #2;
        reset = 1'b1;
        #1;
        chk_reset_quiet("abort0");
        @(posedge clk);
        #1;
        chk_reset_quiet("abort1");
        @(negedge clk);
        reset        = 1'b0;
        prev_illegal = 1'b0;
        run_instr(6'h00);

        for (int n = 0; n < 60; n++) begin
            if (($urandom % 8) == 0)
                run_instr(6'($urandom));
            else
                run_instr(pool[$urandom_range(0, 9)]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Moore-style control FSM that sequences the team's multi-cycle MIPS datapath: one shared memory, one ALU, and the IR/MDR/A/B/ALUOut holding registers. Each instruction is split into 3–5 clock cycles. The block takes the IR opcode and the ALU zero flag and drives every datapath enable and mux select. It replaces the single-cycle `Control` decode when the processor is built in multi-cycle form.

## Interface
Parameters:
- None. The opcode set is fixed.

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high
- `opcode_i`  in  6  IR[31:26]; stable from DECODE until the instruction ends
- `zero_i`  in  1  ALU zero flag, combinational from the datapath
- `pc_en_o`  out  1  PC load enable: `pc_write | (branch_eq & zero_i) | (branch_ne & ~zero_i)`
- `i_or_d_o`  out  1  memory address: 0 = PC, 1 = ALUOut
- `mem_read_o` / `mem_write_o`  out  1 each  memory strobes
- `ir_write_o`  out  1  IR load
- `reg_dst_o`  out  1  write register: 0 = rt, 1 = rd
- `mem_to_reg_o`  out  1  write data: 0 = ALUOut, 1 = MDR
- `reg_write_o`  out  1  register-file write enable
- `alu_src_a_o`  out  1  ALU A: 0 = PC, 1 = A register
- `alu_src_b_o`  out  2  ALU B: 00 = B, 01 = 4, 10 = extended immediate, 11 = extended immediate << 2
- `alu_op_o`  out  3  000 = add, 001 = sub, 010 = R-type (use funct), 011 = or
- `pc_src_o`  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- `instr_done_o`  out  1  one-cycle pulse in the final state of each instruction
- `illegal_o`  out  1  one-cycle pulse after an unsupported opcode is decoded
- `state_o`  out  4  current state, for debug

## Operation
State encoding:
- FETCH = 0, DECODE = 1, MEM_ADR = 2, MEM_READ = 3, MEM_WB = 4, MEM_WRITE = 5
- EXECUTE = 6, ALU_WB = 7, BRANCH = 8, IMM_EXEC = 9, IMM_WB = 10, JUMP = 11

Outputs:
- All outputs decode combinationally from the state register. Any signal not listed for a state is 0.
- `illegal_o` is the only registered output.

State actions and transitions:
- **FETCH**: mem_read = 1, ir_write = 1, src_a = 0, src_b = 01, alu_op = add, pc_src = 00, pc_write = 1. Next state is always DECODE.
- **DECODE**: src_a = 0, src_b = 11, alu_op = add (branch target into ALUOut). Next state by opcode:
  - 0x00 → EXECUTE
  - 0x23 (lw) or 0x2B (sw) → MEM_ADR
  - 0x08 (addi) or 0x0D (ori) → IMM_EXEC
  - 0x04 (beq) or 0x05 (bne) → BRANCH
  - 0x02 (j) → JUMP, see Configuration
  - any other opcode → FETCH, and `illegal_o` is set for the next cycle
- **MEM_ADR**: src_a = 1, src_b = 10, add. Next: MEM_READ if lw, MEM_WRITE if sw.
- **MEM_READ**: mem_read = 1, i_or_d = 1. Next: MEM_WB.
- **MEM_WB**: reg_write = 1, mem_to_reg = 1, reg_dst = 0, done. Next: FETCH.
- **MEM_WRITE**: mem_write = 1, i_or_d = 1, done. Next: FETCH.
- **EXECUTE**: src_a = 1, src_b = 00, alu_op = 010. Next: ALU_WB.
- **ALU_WB**: reg_write = 1, reg_dst = 1, mem_to_reg = 0, done. Next: FETCH.
- **IMM_EXEC**: src_a = 1, src_b = 10, alu_op = add for addi, or for ori. Next: IMM_WB.
- **IMM_WB**: reg_write = 1, reg_dst = 0, done. Next: FETCH.
- **BRANCH**: src_a = 1, src_b = 00, sub, pc_src = 01. branch_eq is set for 0x04, branch_ne for 0x05. done. Next: FETCH.
- **JUMP**: pc_src = 10, pc_write = 1, done. Next: FETCH.

## Timing
- Cycles per instruction: lw 5; R-type, sw, addi and ori 4; beq, bne and j 3; illegal opcode 2, with no architectural writes.
- `pc_en_o` in BRANCH follows `zero_i` in the same cycle. This path is combinational and no flop sits in it.
- Reset assertion:
  - The state goes to FETCH immediately, without waiting for a clock edge.
  - `illegal_o` clears to 0.
  - While `reset` is high, every write and read strobe is forced to 0: pc_en, ir_write, mem_read, mem_write, reg_write, instr_done.
  - Mux selects show their FETCH values.
- Reset release: the first rising edge after release executes FETCH at the PC reset address.
- Reset mid-instruction aborts the instruction. A write strobe from the aborted state must never be asserted after reset asserts.
- Unreachable state codes 12–15 return to FETCH on the next edge, with all strobes 0.

## Configuration
- `MULTICYCLE_JUMP_EN` defined: opcode 0x02 goes to JUMP, and jumps take 3 cycles.
- `MULTICYCLE_JUMP_EN` undefined:
  - JUMP and `pc_src_o` = 10 are never generated.
  - Opcode 0x02 is treated as illegal: DECODE → FETCH and `illegal_o` pulses.

## Test plan
- **Reset, then R-type.** Assert reset mid-cycle; feed opcode 0x00.
  - During reset: all strobes are 0.
  - After release: state sequence 0, 1, 6, 7, 0.
  - reg_write = 1 and reg_dst = 1 only in state 7; instr_done pulses once.
- **lw then sw.** Opcode 0x23 gives sequence 0, 1, 2, 3, 4 with mem_to_reg = 1 in state 4. Opcode 0x2B gives 0, 1, 2, 5 with mem_write = 1 and i_or_d = 1 in state 5.
- **beq.** Opcode 0x04 with zero_i = 1 gives pc_en = 1 in BRANCH. Opcode 0x04 with zero_i = 0 gives pc_en = 0. bne (0x05) gives the inverse.
- **Immediates and jump.** 0x0D gives alu_op = 011 in IMM_EXEC; 0x08 gives 000. 0x02 with the macro defined gives sequence 0, 1, 11 with pc_src = 10. Without the macro, 0x02 gives an illegal_o pulse.
- **Illegal opcode and reset mid-lw.** Opcode 0x3F gives 0, 1, 0 with illegal_o = 1 for exactly one cycle and no reg_write or mem_write. Reset asserted in MEM_READ gives state_o = 0 immediately and no reg_write afterwards.
